im_loadable: RTL and testbench
==============================

Name: im_loadable

Overview:
- Parametrised, synchronous successor to the fixed-program instruction ROM.
- Holds DEPTH instruction words in RAM. After reset, a hardware sweep fills every word with the HALT instruction.
- Programs are loaded at run time through a valid/ready load port.
- Fetches are registered with 1-cycle latency. The CPU fetch stage stalls on busy / iout_valid.

Parameters:
- ADDR_W, 8, fetch/load address width.
- DATA_W, 16, instruction width.
- DEPTH, 256, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- OPC_W, 5, opcode field width; the HALT word is {`HALT, (DATA_W-OPC_W) zeros}.

Ports:
- clock, in, 1, rising-edge clock.
- reset_n, in, 1, synchronous active-low reset.
- fetch_en, in, 1, fetch request this cycle.
- addr, in, ADDR_W, fetch address.
- iout, out, DATA_W, fetched instruction (registered).
- iout_valid, out, 1, iout holds the result of an accepted fetch.
- ld_valid, in, 1, load word offered.
- ld_ready, out, 1, load word can be accepted.
- ld_addr, in, ADDR_W, load address.
- ld_data, in, DATA_W, load data.
- ld_err, out, 1, sticky flag: a load to an address >= DEPTH was dropped.
- busy, out, 1, HALT-fill sweep in progress.

Behaviour:
- Reset: sampled on the clock edge while reset_n=0. Applies regardless of current state, including mid-sweep and mid-load. Reset values:
  - state=CLEAR, clr_cnt=0
  - iout=HALT word, iout_valid=0
  - ld_ready=0, ld_err=0, busy=1
  - RAM contents are not reset directly; the sweep overwrites them.
- FSM, two states:
  - CLEAR: each cycle writes HALT to mem[clr_cnt], then clr_cnt++. On the cycle that writes clr_cnt=DEPTH-1, the next state is READY.
    - busy=1 and ld_ready=0 throughout CLEAR.
    - The sweep lasts exactly DEPTH cycles after reset_n rises.
  - READY: busy=0, ld_ready=1. The FSM stays in READY until reset.
- Load:
  - A word is accepted on a clock edge with ld_valid & ld_ready.
  - If ld_addr < DEPTH: mem[ld_addr] <= ld_data.
  - Else: the write is dropped and ld_err <= 1. ld_err is cleared only by reset.
  - Load inputs are ignored in CLEAR; no error is flagged there.
- Fetch:
  - Fetch in READY with fetch_en=1: next cycle iout_valid=1.
    - iout = mem[addr] if addr < DEPTH, else the HALT word.
  - Fetch in CLEAR with fetch_en=1: next cycle iout_valid=0 and iout=HALT.
  - fetch_en=0: next cycle iout_valid=0; iout holds its previous value.
- Simultaneous load and fetch to the same address: write-first. iout returns ld_data the next cycle.
- Address wrap: no wrap. Out-of-range addresses are handled only by the rules above, never aliased.
- DEPTH not a power of two: clr_cnt compares against DEPTH-1. It does not count to 2**ADDR_W.

Decomposition:
- Shared package / define file:
  - `HALT opcode and the derived HALT-word constant.
  - FSM state encoding localparams (CLEAR, READY).
- One natural sub-module: im_ram_1r1w.
  - Parametrised DATA_W/DEPTH RAM.
  - One synchronous write port, one registered read port, write-first bypass.
- The FSM, write-port mux (sweep vs load), range checks and ld_err stay in the top module.

Test Plan:
- Reset release, DEPTH=256: busy=1 for exactly 256 cycles, then busy=0 and ld_ready=1. A fetch of addr 0x10 returns 16'h0800-style HALT word {`HALT,11'd0} with iout_valid=1 one cycle later.
- Load 19 words (0x4c04, 0x1100, …, 0x0800) at addr 0..18, then fetch 0..20: iout matches each loaded word with 1-cycle latency. Addresses 19 and 20 return the HALT word.
- Same-cycle load addr 5 = 16'hABCD with fetch addr 5: the next cycle shows iout=16'hABCD and iout_valid=1.
- DEPTH=200 instance: load to addr 210 sets ld_err=1 and leaves memory unchanged. Fetch addr 210 returns HALT. Sweep lasts 200 cycles.
- fetch_en=1 during the sweep: iout_valid stays 0 and iout=HALT every cycle.
- Assert reset_n=0 mid-load (after 3 words): on release, busy rises for DEPTH cycles and ld_err=0. A fetch of addr 1 then returns HALT, not the earlier loaded word.

Source files
------------

// File: rtl/im_loadable_pkg.sv
// Shared constants for the loadable instruction memory: HALT opcode and FSM states.
package im_loadable_pkg;

  localparam int HALT_OPC = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/im_ram_1r1w.sv
// Single-clock RAM: one synchronous write port, one registered read port with write-first bypass.
module im_ram_1r1w #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Callers guarantee waddr/raddr < DEPTH whenever we/re are asserted.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/im_loadable.sv
// Loadable instruction memory: HALT-fill sweep after reset, valid/ready load port, 1-cycle fetch.
module im_loadable
  import im_loadable_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int OPC_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] iout,
  output logic              iout_valid,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  output logic              busy
);

  localparam logic [OPC_W-1:0]  HALT_OPC_V = OPC_W'(HALT_OPC);
  localparam logic [DATA_W-1:0] HALT_WORD  = {HALT_OPC_V, {(DATA_W-OPC_W){1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V    = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ld_acc, ld_in_range, fetch_in_range, fetch_ok;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata_p1;
  logic              halt_sel_p1;

  assign ld_ready       = (state == READY);
  assign busy           = (state == CLEAR);
  assign ld_acc         = ld_valid & ld_ready;
  assign ld_in_range    = ({1'b0, ld_addr} < DEPTH_V);
  assign fetch_in_range = ({1'b0, addr} < DEPTH_V);
  assign fetch_ok       = fetch_en & ld_ready & fetch_in_range;

  // Write port is owned by the sweep in CLEAR and by the load port in READY.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    waddr     = ld_addr;
    wdata     = ld_data;
    unique case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = HALT_WORD;
        if (clr_cnt == LAST_ADDR) state_nxt = READY;
      end
      READY: begin
        we = ld_acc & ld_in_range;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      ld_err      <= 1'b0;
      iout_valid  <= 1'b0;
      halt_sel_p1 <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (ld_acc && !ld_in_range) ld_err <= 1'b1;
      if (fetch_en) begin
        iout_valid  <= ld_ready;
        halt_sel_p1 <= !fetch_ok;
      end else begin
        iout_valid  <= 1'b0;
      end
    end
  end

  // ---- stage p1: registered read data, HALT substituted for sweep/out-of-range fetches
  im_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (fetch_ok),
    .raddr (addr),
    .rdata (rdata_p1)
  );

  assign iout = halt_sel_p1 ? HALT_WORD : rdata_p1;

endmodule

// File: tb/tb_im_loadable.sv
// Directed bench for im_loadable: DEPTH=256 and DEPTH=200 instances sharing clock and reset.
module tb_im_loadable;

  localparam logic [15:0] HALT = 16'h0800;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        a_fetch_en, a_iout_valid, a_ld_valid, a_ld_ready, a_ld_err, a_busy;
  logic [7:0]  a_addr, a_ld_addr;
  logic [15:0] a_iout, a_ld_data;
  logic        b_fetch_en, b_iout_valid, b_ld_valid, b_ld_ready, b_ld_err, b_busy;
  logic [7:0]  b_addr, b_ld_addr;
  logic [15:0] b_iout, b_ld_data;

  im_loadable #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .OPC_W(5)) dut_a (
    .clock(clock), .reset_n(reset_n), .fetch_en(a_fetch_en), .addr(a_addr),
    .iout(a_iout), .iout_valid(a_iout_valid), .ld_valid(a_ld_valid), .ld_ready(a_ld_ready),
    .ld_addr(a_ld_addr), .ld_data(a_ld_data), .ld_err(a_ld_err), .busy(a_busy)
  );

  im_loadable #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .OPC_W(5)) dut_b (
    .clock(clock), .reset_n(reset_n), .fetch_en(b_fetch_en), .addr(b_addr),
    .iout(b_iout), .iout_valid(b_iout_valid), .ld_valid(b_ld_valid), .ld_ready(b_ld_ready),
    .ld_addr(b_ld_addr), .ld_data(b_ld_data), .ld_err(b_ld_err), .busy(b_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] prog [19] = '{16'h4c04, 16'h1100, 16'h2201, 16'h3302, 16'h4403,
                             16'h5504, 16'h6605, 16'h7706, 16'h8807, 16'h9908,
                             16'haa09, 16'hbb0a, 16'hcc0b, 16'hdd0c, 16'hee0d,
                             16'hff0e, 16'h1234, 16'h5678, 16'h0800};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs a fixed window after reset release and records the tick at which each busy drops.
  task automatic sweep(output int an, output int bn, output int bad);
    an = 0; bn = 0; bad = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (a_iout_valid !== 1'b0 || a_iout !== HALT) bad++;
      if (a_busy === 1'b0 && an == 0) begin
        an = i; a_fetch_en = 1'b0; a_ld_valid = 1'b0;
      end
      if (b_busy === 1'b0 && bn == 0) begin
        bn = i; b_fetch_en = 1'b0; b_ld_valid = 1'b0;
      end
    end
  endtask

  task automatic fetch(input bit sel_b, input logic [7:0] ad, input logic [15:0] exp, input string tag);
    if (sel_b) begin b_fetch_en = 1'b1; b_addr = ad; end
    else       begin a_fetch_en = 1'b1; a_addr = ad; end
    tick();
    a_fetch_en = 1'b0; b_fetch_en = 1'b0;
    check(tag, sel_b ? b_iout : a_iout, exp);
    check({tag, "_vld"}, sel_b ? b_iout_valid : a_iout_valid, 1'b1);
  endtask

  int an, bn, bad;

  initial begin
    reset_n = 1'b0;
    a_fetch_en = 0; a_addr = 0; a_ld_valid = 0; a_ld_addr = 0; a_ld_data = 0;
    b_fetch_en = 0; b_addr = 0; b_ld_valid = 0; b_ld_addr = 0; b_ld_data = 0;
    repeat (3) tick();
    check("rst_busy",   a_busy, 1'b1);
    check("rst_ready",  a_ld_ready, 1'b0);
    check("rst_vld",    a_iout_valid, 1'b0);
    check("rst_iout",   a_iout, HALT);
    check("rst_err",    a_ld_err, 1'b0);
    check("rst_busy_b", b_busy, 1'b1);

    // Fetch requested throughout the sweep must never produce a valid word.
    a_fetch_en = 1'b1; a_addr = 8'h03;
    reset_n = 1'b1;
    sweep(an, bn, bad);
    check("sweep_len_a", an, 256);
    check("sweep_len_b", bn, 200);
    check("sweep_fetch", bad, 0);
    check("ready_a", a_ld_ready, 1'b1);
    check("ready_b", b_ld_ready, 1'b1);
    check("busy_a",  a_busy, 1'b0);

    fetch(0, 8'h10, HALT, "halt_fetch");

    for (int i = 0; i < 19; i++) begin
      a_ld_valid = 1'b1; a_ld_addr = 8'(i); a_ld_data = prog[i];
      tick();
    end
    a_ld_valid = 1'b0;
    for (int i = 0; i <= 20; i++)
      fetch(0, 8'(i), (i < 19) ? prog[i] : HALT, $sformatf("prog%0d", i));

    fetch(0, 8'h00, 16'h4c04, "pre_hold");
    tick();
    check("hold_vld",  a_iout_valid, 1'b0);
    check("hold_iout", a_iout, 16'h4c04);

    a_ld_valid = 1'b1; a_ld_addr = 8'd5; a_ld_data = 16'habcd;
    a_fetch_en = 1'b1; a_addr = 8'd5;
    tick();
    a_ld_valid = 1'b0; a_fetch_en = 1'b0;
    check("wfirst",     a_iout, 16'habcd);
    check("wfirst_vld", a_iout_valid, 1'b1);
    fetch(0, 8'd5, 16'habcd, "wfirst_rd");
    check("err_a_clean", a_ld_err, 1'b0);

    b_ld_valid = 1'b1; b_ld_addr = 8'd210; b_ld_data = 16'h1234;
    tick();
    check("oor_err", b_ld_err, 1'b1);
    b_ld_addr = 8'd7; b_ld_data = 16'h5555;
    tick();
    b_ld_valid = 1'b0;
    fetch(1, 8'd210, HALT, "oor_fetch");
    fetch(1, 8'd10,  HALT, "no_alias");
    fetch(1, 8'd7,   16'h5555, "b_word7");
    check("err_sticky", b_ld_err, 1'b1);

    for (int i = 0; i < 3; i++) begin
      a_ld_valid = 1'b1; a_ld_addr = 8'(i); a_ld_data = 16'h1111 * 16'(i + 1);
      tick();
    end
    a_ld_addr = 8'd1; a_ld_data = 16'h7777;
    b_ld_valid = 1'b1; b_ld_addr = 8'd250; b_ld_data = 16'h9999;
    reset_n = 1'b0;
    repeat (2) tick();
    check("mid_busy",  a_busy, 1'b1);
    check("mid_ready", a_ld_ready, 1'b0);
    check("mid_err_b", b_ld_err, 1'b0);
    check("mid_iout",  a_iout, HALT);
    reset_n = 1'b1;
    sweep(an, bn, bad);
    check("resweep_a", an, 256);
    check("resweep_b", bn, 200);
    check("clear_ld_err_b", b_ld_err, 1'b0);
    check("clear_ld_err_a", a_ld_err, 1'b0);
    fetch(0, 8'd1, HALT, "wiped1");
    fetch(0, 8'd0, HALT, "wiped0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
